and_1: RTL and testbench

AND_1 -- requirements
Module: and_1

---
 rtl/and_1_pkg.sv | 7 +
 rtl/and_1_sat_counter.sv | 23 ++
 rtl/and_1.sv | 52 +++++
 tb/tb_and_1.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/and_1_pkg.sv
// Shared defaults for the and_1 gate-with-statistics block.
package and_1_pkg;

  localparam int AND1_WIDTH_DEF = 1;
  localparam int AND1_CNT_W_DEF = 16;

endpackage

// File: rtl/and_1_sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic at_max;

  assign at_max = (count == {W{1'b1}});

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && !at_max) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/and_1.sv
// Bitwise AND with a registered copy and a saturating count of all-ones hits.
module and_1
  import and_1_pkg::*;
#(
  parameter int WIDTH = AND1_WIDTH_DEF,
  parameter int CNT_W = AND1_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             en,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_r,
  output logic             valid_o,
  output logic             all_ones,
  output logic [CNT_W-1:0] hit_cnt
);

  logic hit_inc;

  // Combinational path: independent of clk, rst and en.
  assign Q        = A & B;
  assign all_ones = &Q;

  // valid_o is a one-cycle qualifier with no back-pressure: it is high only
  // when the most recent edge captured Q with en=1. Q_r keeps its old value
  // while valid_o is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      Q_r     <= '0;
      valid_o <= 1'b0;
    end else if (en) begin
      Q_r     <= Q;
      valid_o <= 1'b1;
    end else begin
      valid_o <= 1'b0;
    end
  end

  assign hit_inc = en & all_ones;

  sat_counter #(
    .W(CNT_W)
  ) u_hit_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (hit_inc),
    .count(hit_cnt)
  );

endmodule

// File: tb/tb_and_1.sv
// Directed plus randomized checks of and_1 at WIDTH=1 and WIDTH=8/CNT_W=2.
module tb_and_1;

  localparam int CW_A = 16;
  localparam int CW_B = 2;

  // clock / reset block
  logic clk = 1'b0;
  logic clk_run = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  logic [0:0] a1 = '0, b1 = '0;
  logic [7:0] a8 = '0, b8 = '0;

  logic [0:0]      q_a, qr_a;
  logic            valid_a, ones_a;
  logic [CW_A-1:0] cnt_a;
  logic [7:0]      q_b, qr_b;
  logic            valid_b, ones_b;
  logic [CW_B-1:0] cnt_b;

  and_1 dut_a (
    .clk(clk), .rst(rst), .A(a1), .B(b1), .en(en),
    .Q(q_a), .Q_r(qr_a), .valid_o(valid_a), .all_ones(ones_a), .hit_cnt(cnt_a)
  );

  and_1 #(.WIDTH(8), .CNT_W(CW_B)) dut_b (
    .clk(clk), .rst(rst), .A(a8), .B(b8), .en(en),
    .Q(q_b), .Q_r(qr_b), .valid_o(valid_b), .all_ones(ones_b), .hit_cnt(cnt_b)
  );

  int total = 0;
  int bad = 0;

  // scoreboard state
  logic [7:0] exp_q[$];
  logic [7:0] exp_qr_b;
  logic       exp_qr_a;
  logic       exp_valid;
  int         exp_cnt_a;
  int         exp_cnt_b;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: bit i of the result is 1 only when both operand bits are 1.
  function automatic logic [63:0] and_ref(input logic [63:0] a, input logic [63:0] b, input int w);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < w; i++)
      if (a[i] === 1'b1 && b[i] === 1'b1) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic all_ref(input logic [63:0] a, input logic [63:0] b, input int w);
    return and_ref(a, b, w) == ((64'd1 << w) - 64'd1);
  endfunction

  task automatic model_edge();
    logic [63:0] r8;
    logic [63:0] r1;
    r8 = and_ref(64'(a8), 64'(b8), 8);
    r1 = and_ref(64'(a1), 64'(b1), 1);
    if (rst) begin
      exp_qr_a = 1'b0; exp_qr_b = '0; exp_valid = 1'b0;
      exp_cnt_a = 0;   exp_cnt_b = 0;
    end else if (en) begin
      exp_qr_a  = r1[0];
      exp_qr_b  = r8[7:0];
      exp_valid = 1'b1;
      if (all_ref(64'(a1), 64'(b1), 1) && exp_cnt_a < (1 << CW_A) - 1) exp_cnt_a++;
      if (all_ref(64'(a8), 64'(b8), 8) && exp_cnt_b < (1 << CW_B) - 1) exp_cnt_b++;
    end else begin
      exp_valid = 1'b0;
    end
    exp_q.push_back(exp_qr_b);
  endtask

  task automatic check_comb(input string tag);
    check({tag, "_q_a"},    64'(q_a),    and_ref(64'(a1), 64'(b1), 1));
    check({tag, "_ones_a"}, 64'(ones_a), 64'(all_ref(64'(a1), 64'(b1), 1)));
    check({tag, "_q_b"},    64'(q_b),    and_ref(64'(a8), 64'(b8), 8));
    check({tag, "_ones_b"}, 64'(ones_b), 64'(all_ref(64'(a8), 64'(b8), 8)));
  endtask

  task automatic check_regs(input string tag);
    logic [7:0] eq;
    eq = exp_q.pop_front();
    check({tag, "_qr_a"},  64'(qr_a),    64'(exp_qr_a));
    check({tag, "_val_a"}, 64'(valid_a), 64'(exp_valid));
    check({tag, "_cnt_a"}, 64'(cnt_a),   64'(exp_cnt_a));
    check({tag, "_qr_b"},  64'(qr_b),    64'(eq));
    check({tag, "_val_b"}, 64'(valid_b), 64'(exp_valid));
    check({tag, "_cnt_b"}, 64'(cnt_b),   64'(exp_cnt_b));
  endtask

  // driver: one clock edge, model update, then sample 1 ns later
  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_regs(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int steps_a[4];
    int exp_hits[5];
    steps_a  = '{0, 2, 1, 3};
    exp_hits = '{1, 2, 3, 3, 3};

    // Truth table with the clock stopped.
    for (int i = 0; i < 4; i++) begin
      a1 = steps_a[i][1];
      b1 = steps_a[i][0];
      #1;
      check("tt_q", 64'(q_a), 64'(steps_a[i] == 3));
      check("tt_ones", 64'(ones_a), 64'(steps_a[i] == 3));
      #9;
    end

    a8 = 8'hF0; b8 = 8'h3C; #1;
    check("w8_q", 64'(q_b), 64'h30);
    check("w8_ones", 64'(ones_b), 64'd0);
    a8 = 8'hFF; b8 = 8'hFF; #1;
    check("w8ff_q", 64'(q_b), 64'hFF);
    check("w8ff_ones", 64'(ones_b), 64'd1);

    // Reset with clock running; Q must still follow A & B.
    clk_run = 1'b1;
    rst = 1'b1; en = 1'b0; a8 = 8'h5A; b8 = 8'h0F;
    tick("rst0");
    check_comb("rst0c");
    tick("rst1");
    check("rst_qr_b", 64'(qr_b), 64'd0);
    check("rst_cnt_b", 64'(cnt_b), 64'd0);
    rst = 1'b0;

    // Capture then hold.
    a1 = 1'b1; b1 = 1'b1; a8 = 8'h00; en = 1'b1;
    tick("cap");
    check("cap_qr", 64'(qr_a), 64'd1);
    check("cap_valid", 64'(valid_a), 64'd1);
    en = 1'b0; a1 = 1'b0;
    tick("hold");
    check("hold_qr", 64'(qr_a), 64'd1);
    check("hold_valid", 64'(valid_a), 64'd0);

    // Saturation at CNT_W=2.
    rst = 1'b1; tick("rst2"); rst = 1'b0;
    en = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      tick("sat");
      check("sat_cnt", 64'(cnt_b), 64'(exp_hits[i]));
    end

    // Reset wins over en on the same edge.
    rst = 1'b1; tick("rst3"); rst = 1'b0;
    tick("pre1"); tick("pre2");
    check("pre_cnt", 64'(cnt_b), 64'd2);
    rst = 1'b1; en = 1'b1; b8 = 8'h7E;
    tick("prio");
    check("prio_qr", 64'(qr_b), 64'd0);
    check("prio_valid", 64'(valid_b), 64'd0);
    check("prio_cnt", 64'(cnt_b), 64'd0);
    check("prio_q", 64'(q_b), 64'h7E);
    rst = 1'b0;

    // Randomized traffic, biased toward all-ones operands.
    for (int n = 0; n < 300; n++) begin
      rst = ($urandom_range(0, 19) == 0);
      en  = ($urandom_range(0, 3) != 0);
      a1  = 1'($urandom_range(0, 1));
      b1  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) begin
        a8 = 8'hFF; b8 = 8'hFF;
      end else begin
        a8 = 8'($urandom); b8 = 8'($urandom);
      end
      #1;
      check_comb("rnd");
      tick("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
